// File: rtl/app_mem_arbiter.sv
// Two-requester arbiter for the single-port application data memory (1 = UPDI loader, 0 = stream).
// Define APP_ARB_ROUND_ROBIN_EN for round-robin contention; otherwise requester 0 has fixed priority.
module app_mem_arbiter #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_resetn,
    input  logic [1:0]        i_req_valid,
    output logic [1:0]        o_req_ready,
    input  logic [1:0]        i_req_we,
    input  logic [1:0]        i_req_lock,
    input  logic [ADDR_W-1:0] i_req_addr0,
    input  logic [ADDR_W-1:0] i_req_addr1,
    input  logic [DATA_W-1:0] i_req_wdata0,
    input  logic [DATA_W-1:0] i_req_wdata1,
    output logic [1:0]        o_rsp_valid,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    typedef enum logic [1:0] {StFree, StOwn0, StOwn1} state_e;

    state_e            state_q, state_d;
    logic [1:0]        ready;
    logic              accept;
    logic              gnt_id;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              tag_rd_q, tag_rd_d;
    logic              tag_id_q, tag_id_d;
    logic [1:0]        rsp_valid_q, rsp_valid_d;
`ifdef APP_ARB_ROUND_ROBIN_EN
    logic              last_q, last_d;
`endif

    // Grant is combinational; forced off while reset is held.
    always_comb begin
        ready = 2'b00;
        unique case (state_q)
            StFree: begin
                if (i_req_valid == 2'b11) begin
`ifdef APP_ARB_ROUND_ROBIN_EN
                    ready = last_q ? 2'b01 : 2'b10;
`else
                    ready = 2'b01;
`endif
                end else begin
                    ready = i_req_valid;
                end
            end
            StOwn0:  ready = {1'b0, i_req_valid[0]};
            StOwn1:  ready = {i_req_valid[1], 1'b0};
            default: ready = 2'b00;
        endcase
        if (!i_resetn) begin
            ready = 2'b00;
        end
    end

    assign gnt_id      = ready[1];
    assign accept      = |ready;
    assign o_req_ready = ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFree: begin
                if (accept && i_req_lock[gnt_id]) begin
                    state_d = gnt_id ? StOwn1 : StOwn0;
                end
            end
            StOwn0:  if (!i_req_lock[0]) state_d = StFree;
            StOwn1:  if (!i_req_lock[1]) state_d = StFree;
            default: state_d = StFree;
        endcase
    end

    always_comb begin
        mem_en_d    = accept;
        mem_we_d    = accept & i_req_we[gnt_id];
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (accept) begin
            mem_addr_d  = gnt_id ? i_req_addr1 : i_req_addr0;
            mem_wdata_d = gnt_id ? i_req_wdata1 : i_req_wdata0;
        end
        // Tag travels with the command, then lines up with the memory read data.
        tag_rd_d    = accept & ~i_req_we[gnt_id];
        tag_id_d    = gnt_id;
        rsp_valid_d = 2'b00;
        if (tag_rd_q) begin
            rsp_valid_d[tag_id_q] = 1'b1;
        end
    end

`ifdef APP_ARB_ROUND_ROBIN_EN
    always_comb begin
        last_d = accept ? gnt_id : last_q;
    end
`endif

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state_q     <= StFree;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            tag_rd_q    <= 1'b0;
            tag_id_q    <= 1'b0;
            rsp_valid_q <= 2'b00;
`ifdef APP_ARB_ROUND_ROBIN_EN
            last_q      <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            tag_rd_q    <= tag_rd_d;
            tag_id_q    <= tag_id_d;
            rsp_valid_q <= rsp_valid_d;
`ifdef APP_ARB_ROUND_ROBIN_EN
            last_q      <= last_d;
`endif
        end
    end

    assign o_mem_en    = mem_en_q;
    assign o_mem_we    = mem_we_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = mem_wdata_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_data  = (|rsp_valid_q) ? i_mem_rdata : '0;

endmodule

// File: tb/tb_app_mem_arbiter.sv
// Self-checking bench for app_mem_arbiter: vector table, randomized traffic against a
// transaction-level model, and hand-written lock / streaming / reset sequences.
module tb_app_mem_arbiter;

`ifdef APP_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       resetn;
    logic [1:0] req_valid, req_ready, req_we, req_lock, rsp_valid;
    logic [7:0] addr0, addr1, wdata0, wdata1, rsp_data;
    logic       mem_en, mem_we;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0] mem [256];
    logic [7:0] shadow [256];
    bit         mem_inited = 1'b0;
    int         checks = 0;
    int         failures = 0;

    // Transaction-level model state
    int         owner;
    int         last;
    bit         e0_v, e1_v;
    int         e0_id, e1_id;
    logic [7:0] e0_d, e1_d;
    bit         c_en, c_we;
    logic [7:0] c_addr, c_wd;

    always #5 clk = ~clk;

    app_mem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .i_clk       (clk),
        .i_resetn    (resetn),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_we    (req_we),
        .i_req_lock  (req_lock),
        .i_req_addr0 (addr0),
        .i_req_addr1 (addr1),
        .i_req_wdata0(wdata0),
        .i_req_wdata1(wdata1),
        .o_rsp_valid (rsp_valid),
        .o_rsp_data  (rsp_data),
        .o_mem_en    (mem_en),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata)
    );

    // Synchronous single-port memory; contents set once during the first reset.
    always @(posedge clk) begin
        if (!mem_inited) begin
            for (int a = 0; a < 256; a++) mem[a] = (a == 0) ? 8'd120 : ~8'(a);
            mem_inited = 1'b1;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] = mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        owner = -1;
        last  = 1;
        e0_v  = 1'b0;
        e1_v  = 1'b0;
        c_en  = 1'b0;
    endtask

    // Called once per cycle with inputs stable: checks outputs, then advances the model.
    task automatic model_cycle(output int acc);
        logic [1:0] er;
        er = 2'b00;
        if (owner == 0)                er[0] = req_valid[0];
        else if (owner == 1)           er[1] = req_valid[1];
        else if (req_valid == 2'b11)   er = (RR && last == 0) ? 2'b10 : 2'b01;
        else                           er = req_valid;
        chk("ready", req_ready, er);
        chk("rsp_valid", rsp_valid, e0_v ? ((e0_id == 1) ? 2'b10 : 2'b01) : 2'b00);
        if (e0_v) chk("rsp_data", rsp_data, e0_d);
        chk("mem_en", mem_en, c_en);
        if (c_en) begin
            chk("mem_we", mem_we, c_we);
            chk("mem_addr", mem_addr, c_addr);
            if (c_we) chk("mem_wdata", mem_wdata, c_wd);
        end
        acc  = er[1] ? 1 : (er[0] ? 0 : -1);
        e0_v = e1_v; e0_id = e1_id; e0_d = e1_d;
        e1_v = 1'b0;
        c_en = 1'b0;
        if (acc >= 0) begin
            c_en   = 1'b1;
            c_we   = req_we[acc];
            c_addr = (acc == 1) ? addr1 : addr0;
            c_wd   = (acc == 1) ? wdata1 : wdata0;
            if (c_we) shadow[c_addr] = c_wd;
            else begin
                e1_v = 1'b1; e1_id = acc; e1_d = shadow[c_addr];
            end
            last = acc;
        end
        if (owner >= 0) begin
            if (!req_lock[owner]) owner = -1;
        end else if (acc >= 0 && req_lock[acc]) begin
            owner = acc;
        end
    endtask

    task automatic cyc(input logic [1:0] v, input logic [1:0] we, input logic [1:0] lk,
                       input logic [7:0] a0, input logic [7:0] a1,
                       input logic [7:0] d0, input logic [7:0] d1, output int acc);
        @(posedge clk);
        #1;
        req_valid = v; req_we = we; req_lock = lk;
        addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
        @(negedge clk);
        model_cycle(acc);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, req_ready, 2'b00);
        chk({tag, "_mem_en"}, mem_en, 1'b0);
        chk({tag, "_mem_we"}, mem_we, 1'b0);
        chk({tag, "_mem_addr"}, mem_addr, 8'h00);
        chk({tag, "_mem_wdata"}, mem_wdata, 8'h00);
        chk({tag, "_rsp_valid"}, rsp_valid, 2'b00);
        chk({tag, "_rsp_data"}, rsp_data, 8'h00);
    endtask

    typedef struct packed {
        logic [1:0] v, we, lk;
        logic [7:0] a0, a1, d1;
        logic [1:0] rdy_fp, rdy_rr, rv_fp, rv_rr;
        logic [7:0] rd_fp, rd_rr;
    } vec_t;

    vec_t       tbl [17];
    int         acc;
    logic [1:0] pv, pwe, lk;
    logic [7:0] pa [2];
    logic [7:0] pd [2];
    int         stream_n;

    initial begin
        // v, we, lk, a0, a1, d1, ready fp/rr, rsp_valid fp/rr, rsp_data fp/rr
        tbl[0]  = '{2'b01, 2'b00, 2'b00, 8'd0, 8'd0, 8'h00, 2'b01, 2'b01, 2'b00, 2'b00, 8'h00, 8'h00};
        tbl[1]  = '{2'b10, 2'b10, 2'b00, 8'd0, 8'd5, 8'hA5, 2'b10, 2'b10, 2'b00, 2'b00, 8'h00, 8'h00};
        tbl[2]  = '{2'b01, 2'b00, 2'b00, 8'd5, 8'd0, 8'h00, 2'b01, 2'b01, 2'b01, 2'b01, 8'd120, 8'd120};
        tbl[3]  = '{2'b00, 2'b00, 2'b00, 8'd0, 8'd0, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00};
        tbl[4]  = '{2'b11, 2'b00, 2'b00, 8'd1, 8'd2, 8'h00, 2'b01, 2'b10, 2'b01, 2'b01, 8'hA5, 8'hA5};
        tbl[5]  = '{2'b11, 2'b00, 2'b00, 8'd1, 8'd2, 8'h00, 2'b01, 2'b01, 2'b00, 2'b00, 8'h00, 8'h00};
        tbl[6]  = '{2'b11, 2'b00, 2'b00, 8'd1, 8'd2, 8'h00, 2'b01, 2'b10, 2'b01, 2'b10, 8'hFE, 8'hFD};
        tbl[7]  = '{2'b00, 2'b00, 2'b00, 8'd0, 8'd0, 8'h00, 2'b00, 2'b00, 2'b01, 2'b01, 8'hFE, 8'hFE};
        tbl[8]  = '{2'b00, 2'b00, 2'b00, 8'd0, 8'd0, 8'h00, 2'b00, 2'b00, 2'b01, 2'b10, 8'hFE, 8'hFD};
        tbl[9]  = '{2'b10, 2'b10, 2'b10, 8'd0, 8'd9, 8'h33, 2'b10, 2'b10, 2'b00, 2'b00, 8'h00, 8'h00};
        tbl[10] = '{2'b01, 2'b00, 2'b10, 8'd9, 8'd0, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00};
        tbl[11] = '{2'b01, 2'b00, 2'b00, 8'd9, 8'd0, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00};
        tbl[12] = '{2'b01, 2'b00, 2'b00, 8'd9, 8'd0, 8'h00, 2'b01, 2'b01, 2'b00, 2'b00, 8'h00, 8'h00};
        tbl[13] = '{2'b00, 2'b00, 2'b00, 8'd0, 8'd0, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00};
        tbl[14] = '{2'b00, 2'b00, 2'b00, 8'd0, 8'd0, 8'h00, 2'b00, 2'b00, 2'b01, 2'b01, 8'h33, 8'h33};
        tbl[15] = '{2'b01, 2'b00, 2'b10, 8'd3, 8'd0, 8'h00, 2'b01, 2'b01, 2'b00, 2'b00, 8'h00, 8'h00};
        tbl[16] = '{2'b01, 2'b00, 2'b00, 8'd4, 8'd0, 8'h00, 2'b01, 2'b01, 2'b00, 2'b00, 8'h00, 8'h00};

        for (int a = 0; a < 256; a++) shadow[a] = (a == 0) ? 8'd120 : ~8'(a);
        req_valid = 2'b11; req_we = 2'b00; req_lock = 2'b00;
        addr0 = 8'h00; addr1 = 8'h00; wdata0 = 8'h00; wdata1 = 8'h00;
        resetn = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("init_reset");
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        resetn = 1'b1;

        // Directed vectors
        for (int i = 0; i < 17; i++) begin
            cyc(tbl[i].v, tbl[i].we, tbl[i].lk, tbl[i].a0, tbl[i].a1, 8'h00, tbl[i].d1, acc);
            chk($sformatf("vec%0d_ready", i), req_ready, RR ? tbl[i].rdy_rr : tbl[i].rdy_fp);
            chk($sformatf("vec%0d_rsp_valid", i), rsp_valid, RR ? tbl[i].rv_rr : tbl[i].rv_fp);
            if ((RR ? tbl[i].rv_rr : tbl[i].rv_fp) != 2'b00)
                chk($sformatf("vec%0d_rsp_data", i), rsp_data, RR ? tbl[i].rd_rr : tbl[i].rd_fp);
        end
        repeat (2) cyc(2'b00, 2'b00, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0, acc);

        // Randomized traffic; unaccepted requests are held stable
        pv = 2'b00; pwe = 2'b00; lk = 2'b00;
        pa[0] = 8'd128; pa[1] = 8'd128; pd[0] = 8'd0; pd[1] = 8'd0;
        for (int n = 0; n < 400; n++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pv[r] && $urandom_range(2) != 0) begin
                    pv[r]  = 1'b1;
                    pwe[r] = 1'($urandom_range(1));
                    pa[r]  = 8'(128 + $urandom_range(127));
                    pd[r]  = 8'($urandom);
                end
                if (owner == r) lk[r] = ($urandom_range(3) != 0);
                else            lk[r] = ($urandom_range(5) == 0);
            end
            cyc(pv, pwe, lk, pa[0], pa[1], pd[0], pd[1], acc);
            if (acc >= 0) pv[acc] = 1'b0;
        end
        repeat (3) cyc(2'b00, 2'b00, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0, acc);

        // Locked burst: requester 1 writes 1..120 while requester 0 waits
        for (int i = 1; i <= 120; i++) begin
            cyc((i == 1) ? 2'b10 : 2'b11, 2'b10, 2'b10, 8'd0, 8'(i), 8'd0, 8'(i), acc);
            chk("lock_owner_ready", req_ready, 2'b10);
        end
        cyc(2'b01, 2'b00, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0, acc);
        chk("lock_drop_ready", req_ready, 2'b00);
        cyc(2'b01, 2'b00, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0, acc);
        chk("lock_release_grant", req_ready, 2'b01);
        repeat (2) cyc(2'b00, 2'b00, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0, acc);

        // Streaming read of 0..120
        stream_n = 0;
        for (int i = 0; i < 123; i++) begin
            cyc((i < 121) ? 2'b01 : 2'b00, 2'b00, 2'b00, 8'(i), 8'd0, 8'd0, 8'd0, acc);
            if (rsp_valid == 2'b01) begin
                chk("stream_data", rsp_data, (stream_n == 0) ? 32'd120 : 32'(stream_n));
                stream_n++;
            end
        end
        chk("stream_count", stream_n, 121);

        // Reset one cycle after a locked read accept
        cyc(2'b01, 2'b00, 2'b01, 8'd7, 8'd0, 8'd0, 8'd0, acc);
        @(posedge clk);
        #1;
        resetn = 1'b0;
        req_valid = 2'b11;
        #1;
        chk_reset_outputs("mid_reset");
        @(negedge clk);
        chk_reset_outputs("held_reset");
        @(posedge clk);
        #1;
        resetn = 1'b1;
        req_valid = 2'b00;
        req_lock = 2'b00;
        model_reset();
        repeat (3) cyc(2'b00, 2'b00, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0, acc);
        cyc(2'b11, 2'b00, 2'b00, 8'd1, 8'd2, 8'd0, 8'd0, acc);
        chk("post_reset_grant", req_ready, 2'b01);
        repeat (2) cyc(2'b00, 2'b00, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0, acc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/app_mem_arbiter.md
# app_mem_arbiter

Two-port arbiter that shares the single-port application data memory between the UPDI-side loader (requester 1) and the application stream reader (requester 0). It accepts read/write requests on independent valid/ready ports, issues at most one memory access per cycle, and returns read data to the issuing requester with fixed latency. It sits between the requesters inside `top_APP` and the memory instance, replacing direct memory wiring.

## Interface
- `ADDR_W`, 8, memory address width
- `DATA_W`, 8, memory data width

- `i_clk`  in  1  clock, all logic on rising edge
- `i_resetn`  in  1  reset, asynchronous, active-low
- `i_req_valid`  in  2  per-requester request valid (bit r = requester r)
- `o_req_ready`  out  2  per-requester request accepted when valid&ready
- `i_req_we`  in  2  1 = write, 0 = read
- `i_req_lock`  in  2  requester holds ownership while high
- `i_req_addr0`, `i_req_addr1`  in  ADDR_W  request address
- `i_req_wdata0`, `i_req_wdata1`  in  DATA_W  write data
- `o_rsp_valid`  out  2  one-cycle read-data strobe per requester
- `o_rsp_data`  out  DATA_W  read data, valid when any `o_rsp_valid` bit is high
- `o_mem_en`, `o_mem_we`  out  1  memory access enable / write enable
- `o_mem_addr`  out  ADDR_W  memory address
- `o_mem_wdata`  out  DATA_W  memory write data
- `i_mem_rdata`  in  DATA_W  memory read data, valid one cycle after `o_mem_en` with `o_mem_we`=0

## Operation
- Ownership FSM: `FREE`, `OWN0`, `OWN1`; reset → `FREE`.
- `FREE`: grant by arbitration policy among valid requesters; at most one `o_req_ready` bit high; ready is combinational from valid and state.
- Acceptance of requester r with `i_req_lock[r]`=1 → `OWNr`.
- `OWNr`: only requester r may be granted (`o_req_ready[r]` = `i_req_valid[r]`), other bit forced 0 even if r is idle; exit to `FREE` on the cycle `i_req_lock[r]` is sampled 0.
- Accepted request registered into memory command stage: `o_mem_en`=1, `o_mem_we`, `o_mem_addr`, `o_mem_wdata` driven the cycle after acceptance; `o_mem_en`=0 otherwise.
- Read tag (requester id, read flag) pipelined 2 stages alongside; `o_rsp_valid[tag]` pulses with `o_rsp_data` = `i_mem_rdata`.
- Writes produce no response.
- Responses are unconditional; requesters must always sink them.

## Timing
- Reset values: `o_req_ready`=0 (during reset), `o_mem_en`=0, `o_mem_we`=0, `o_mem_addr`=0, `o_mem_wdata`=0, `o_rsp_valid`=0, `o_rsp_data`=0, FSM `FREE`, RR pointer = 1.
- Latency: accept at cycle N → memory access N+1 → `o_rsp_valid` at N+2.
- Throughput: one accepted request per cycle, back-to-back across requesters allowed.
- Read-after-write to same address by any requester in consecutive cycles returns the new data (memory ordering equals acceptance order).
- Simultaneous valid from both in `FREE`: policy decides; loser sees ready=0 and must hold request stable.
- Lock asserted on a request not accepted has no effect.
- Reset mid-operation: in-flight command and response stages discarded, no `o_rsp_valid` after reset release until a new read is accepted.

## Configuration
- `APP_ARB_ROUND_ROBIN_EN` defined: in `FREE`, on contention, grant the requester other than the last granted; pointer updates on every acceptance; after reset requester 0 wins first contention.
- Undefined: fixed priority, requester 0 always wins contention; no pointer register.
- Lock behaviour identical in both builds.

## Test plan
- Single read: mem[0]=120, requester 0 reads addr 0 → ready same cycle, `o_mem_en` next cycle, `o_rsp_valid`=2'b01 with data 120 two cycles after accept.
- Write-then-read: requester 1 writes addr 5 = 8'hA5, requester 0 reads addr 5 next cycle → response 8'hA5.
- Contention: both valid continuously reading addr 1..4 → RR build alternates grants 0,1,0,1 starting with 0; fixed build grants only 0 until it drops valid.
- Lock: requester 1 writes 120 bytes to addr 1..120 with lock high, requester 0 valid throughout → requester 0 ready stays 0 until lock drops, then granted next cycle; readback matches values 1..120.
- Streaming: requester 0 reads addr 0..120 back-to-back → 121 responses, one per cycle, in order, data = address (mem[0]=120).
- Reset mid-burst: assert `i_resetn`=0 one cycle after a read accept → no `o_rsp_valid`, all outputs at reset values, FSM `FREE` after release.
